// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding fetch at a time,
// and holds the fetched word for the decoder until it is consumed.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= RESET_PC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // A stalled decode freezes everything, including a pending redirect.
                if (!stall) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                    if (PCSrc && valid_q) begin
                        pc_d = {branch_target[31:2], 2'b00};
                        if (branch_target[1:0] != 2'b00) misalign_d = 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req    = (state_q == FETCH) && !RESET;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign misalign    = misalign_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] BEQ = 32'h00208463;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .stall(stall), .PCSrc(PCSrc),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .op(op),
        .pc_out(pc_out), .instr_valid(instr_valid), .misalign(misalign),
        .fetch_count(fetch_count)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESET = 1'b1; stall = 1'b0; PCSrc = 1'b0; branch_target = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        @(negedge CLK); @(negedge CLK);
        checks++;
        if ({imem_req, instr_valid, misalign} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: req/valid/misalign=%b expected 000", {imem_req, instr_valid, misalign});
        end
        checks++;
        if (instr !== NOP || op !== 7'b0010011) begin
            errors++; $display("FAIL reset_instr: instr=%h op=%b expected %h 0010011", instr, op, NOP);
        end
        checks++;
        if (imem_addr !== 32'd0 || pc_out !== 32'd0 || fetch_count !== 32'd0) begin
            errors++; $display("FAIL reset_regs: addr=%h pc_out=%h count=%0d expected 0 0 0", imem_addr, pc_out, fetch_count);
        end
        RESET = 1'b0;
    endtask

    task automatic test_zero_wait();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL zw_first_req: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
        imem_ready = 1'b1; imem_rdata = 32'h00500093;
        @(negedge CLK);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h00500093 || op !== 7'b0010011 || pc_out !== 32'd0) begin
            errors++; $display("FAIL zw_hold: valid=%b instr=%h op=%b pc_out=%h expected 1 00500093 0010011 0", instr_valid, instr, op, pc_out);
        end
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd4) begin
            errors++; $display("FAIL zw_next_addr: req=%b addr=%h expected 0 00000004", imem_req, imem_addr);
        end
        imem_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (fetch_count !== 32'd1 || instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1) begin
            errors++; $display("FAIL zw_consume: count=%0d valid=%b instr=%h req=%b expected 1 0 %h 1", fetch_count, instr_valid, instr, imem_req, NOP);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd4 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL wait_req[%0d]: req=%b addr=%h valid=%b expected 1 00000004 0", i, imem_req, imem_addr, instr_valid);
            end
            imem_ready = (i == 3);
            imem_rdata = 32'h00A00113;
            stall      = (i == 3);
            @(negedge CLK);
        end
        imem_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'd4 || instr !== 32'h00A00113) begin
            errors++; $display("FAIL wait_done: valid=%b pc_out=%h instr=%h expected 1 00000004 00a00113", instr_valid, pc_out, instr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (instr !== 32'h00A00113 || pc_out !== 32'd4 || instr_valid !== 1'b1 || imem_req !== 1'b0 || fetch_count !== 32'd1) begin
                errors++; $display("FAIL stall_hold[%0d]: instr=%h pc_out=%h valid=%b req=%b count=%0d", i, instr, pc_out, instr_valid, imem_req, fetch_count);
            end
        end
        stall = 1'b0;
        @(negedge CLK);
        checks++;
        if (fetch_count !== 32'd2 || instr_valid !== 1'b0 || imem_addr !== 32'd8) begin
            errors++; $display("FAIL stall_release: count=%0d valid=%b addr=%h expected 2 0 00000008", fetch_count, instr_valid, imem_addr);
        end
    endtask

    task automatic test_branch();
        // PCSrc with nothing held must not redirect.
        PCSrc = 1'b1; branch_target = 32'h00000100;
        @(negedge CLK);
        checks++;
        if (imem_addr !== 32'd8 || imem_req !== 1'b1) begin
            errors++; $display("FAIL branch_no_valid: addr=%h req=%b expected 00000008 1", imem_addr, imem_req);
        end
        PCSrc = 1'b0;
        imem_ready = 1'b1; imem_rdata = BEQ; stall = 1'b1;
        @(negedge CLK);
        checks++;
        if (op !== 7'b1100011 || pc_out !== 32'd8) begin
            errors++; $display("FAIL branch_held: op=%b pc_out=%h expected 1100011 00000008", op, pc_out);
        end
        imem_ready = 1'b0; stall = 1'b0; PCSrc = 1'b1; branch_target = 32'h00000040;
        @(negedge CLK);
        checks++;
        if (imem_addr !== 32'h40 || misalign !== 1'b0 || fetch_count !== 32'd3) begin
            errors++; $display("FAIL branch_taken: addr=%h misalign=%b count=%0d expected 00000040 0 3", imem_addr, misalign, fetch_count);
        end
        PCSrc = 1'b0; imem_ready = 1'b1; stall = 1'b1;
        @(negedge CLK);
        imem_ready = 1'b0; stall = 1'b0; PCSrc = 1'b1; branch_target = 32'h00000042;
        @(negedge CLK);
        checks++;
        if (imem_addr !== 32'h40 || misalign !== 1'b1) begin
            errors++; $display("FAIL branch_misalign: addr=%h misalign=%b expected 00000040 1", imem_addr, misalign);
        end
        PCSrc = 1'b0;
    endtask

    task automatic test_stall_pcsrc();
        imem_ready = 1'b1; imem_rdata = BEQ; stall = 1'b1;
        @(negedge CLK);
        imem_ready = 1'b0; PCSrc = 1'b1; branch_target = 32'h00000080;
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (imem_addr !== 32'h44 || instr_valid !== 1'b1 || pc_out !== 32'h40) begin
            errors++; $display("FAIL pcsrc_stalled: addr=%h valid=%b pc_out=%h expected 00000044 1 00000040", imem_addr, instr_valid, pc_out);
        end
        stall = 1'b0; PCSrc = 1'b0;
        @(negedge CLK);
        checks++;
        if (imem_addr !== 32'h44 || fetch_count !== 32'd5 || misalign !== 1'b1) begin
            errors++; $display("FAIL pcsrc_dropped: addr=%h count=%0d misalign=%b expected 00000044 5 1", imem_addr, fetch_count, misalign);
        end
    endtask

    task automatic test_pc_wrap();
        imem_ready = 1'b1; imem_rdata = BEQ; stall = 1'b1;
        @(negedge CLK);
        imem_ready = 1'b0; stall = 1'b0; PCSrc = 1'b1; branch_target = 32'hFFFFFFFC;
        @(negedge CLK);
        checks++;
        if (imem_addr !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL wrap_target: addr=%h expected fffffffc", imem_addr);
        end
        PCSrc = 1'b0; imem_ready = 1'b1; imem_rdata = NOP; stall = 1'b1;
        @(negedge CLK);
        imem_ready = 1'b0; stall = 1'b0;
        @(negedge CLK);
        checks++;
        if (imem_addr !== 32'd0 || fetch_count !== 32'd7 || imem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_next: addr=%h count=%0d req=%b expected 00000000 7 1", imem_addr, fetch_count, imem_req);
        end
    endtask

    task automatic test_reset_mid_fetch();
        imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF; RESET = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_req: req=%b expected 0", imem_req);
        end
        @(negedge CLK);
        checks++;
        if (instr !== NOP || instr_valid !== 1'b0 || imem_addr !== 32'd0 || imem_req !== 1'b0 || misalign !== 1'b0 || fetch_count !== 32'd0) begin
            errors++; $display("FAIL rst_mid_state: instr=%h valid=%b addr=%h req=%b misalign=%b count=%0d", instr, instr_valid, imem_addr, imem_req, misalign, fetch_count);
        end
        RESET = 1'b0; imem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch();
        test_stall_pcsrc();
        test_pc_wrap();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
